// File: rtl/input_port_buffer.sv
// Per-input-port flit FIFO: buffers flits, hands head destinations to route computation and
// presents the packet with its latched output port until the tail leaves.

package params_noc;
  typedef enum logic [2:0] {LOCAL, NORTH, EAST, SOUTH, WEST} inout_Port;
endpackage

module input_port_buffer
  import params_noc::*;
#(
  parameter int unsigned BUFFER_DEPTH    = 4,
  parameter int unsigned FLIT_SIZE       = 16,
  parameter int unsigned x_Des_Addr_Size = 5,
  parameter int unsigned y_Des_Addr_Size = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FLIT_SIZE-1:0]       data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [x_Des_Addr_Size-1:0] x_Dest,
  output logic [y_Des_Addr_Size-1:0] y_Dest,
  input  inout_Port                  port_i,
  output logic [FLIT_SIZE-1:0]       flit_o,
  output logic                       valid_o,
  input  logic                       read_i,
  output inout_Port                  out_port_o,
  output logic                       error_o
);

  localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CntW = $clog2(BUFFER_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRoute, StActive} state_e;

  logic [FLIT_SIZE-1:0] mem_q [BUFFER_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  state_e               state_q;

  logic [FLIT_SIZE-1:0] front;
  logic [1:0]           front_type;
  logic                 not_empty;
  logic                 front_head;
  logic                 front_tail;
  logic                 push;
  logic                 pop;
  logic                 drop;

  assign front      = mem_q[rd_ptr_q];
  assign front_type = front[FLIT_SIZE-1 -: 2];
  assign not_empty  = (count_q != '0);
  // HEAD = 00, HEADTAIL = 11; TAIL and HEADTAIL both have the upper type bit set.
  assign front_head = (front_type == 2'b00) || (front_type == 2'b11);
  assign front_tail = front_type[1];

  assign ready_o = (count_q != CntW'(BUFFER_DEPTH));
  assign valid_o = (state_q == StActive) && not_empty;
  assign flit_o  = front;

  assign push = valid_i && ready_o;
  assign drop = (state_q == StIdle) && not_empty && !front_head;
  assign pop  = drop || (valid_o && read_i);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      x_Dest     <= '0;
      y_Dest     <= '0;
      out_port_o <= LOCAL;
      error_o    <= 1'b0;
    end else begin
      error_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (not_empty) begin
            if (front_head) begin
              x_Dest  <= front[FLIT_SIZE-3 -: x_Des_Addr_Size];
              y_Dest  <= front[FLIT_SIZE-3-x_Des_Addr_Size -: y_Des_Addr_Size];
              state_q <= StRoute;
            end else begin
              error_o <= 1'b1;
            end
          end
        end
        StRoute: begin
          out_port_o <= port_i;
          state_q    <= StActive;
        end
        StActive: begin
          if (valid_o && read_i && front_tail) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
